call_scheduler: RTL and testbench

- LOOK-policy request scheduler for the elevator car.
- Latches cabin calls and hall up/down calls, and picks the next stop from current floor and sweep direction.
- Hands the stop to the motion FSM via a valid/ack handshake, then clears served calls on arrival.
- Sits between the button inputs and the motion/door FSM; its registered pending vectors drive the call lamps.

---
 rtl/elev_pkg.sv | 18 +
 rtl/look_picker.sv | 68 ++++++
 rtl/call_scheduler.sv | 117 +++++++++++
 tb/tb_call_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared constants and state encoding for the elevator call scheduler.
package elev_pkg;

  localparam int FLOORS  = 6;
  localparam int FLOOR_W = 3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DISPATCH,
    SERVE,
    CLEAR
  } state_t;

endpackage

// File: rtl/look_picker.sv
// Combinational LOOK stop selection from the latched call vectors.
module look_picker
  import elev_pkg::*;
(
  input  logic [FLOORS-1:0]  pend_car,
  input  logic [FLOORS-2:0]  pend_up,
  input  logic [FLOORS-2:0]  pend_dn,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               dir,
  output logic               pick_valid,
  output logic [FLOOR_W-1:0] pick_floor,
  output logic               pick_dir
);

  logic [FLOORS-1:0] up_f;
  logic [FLOORS-1:0] dn_f;
  int cur;
  int a_f, b_f, c_f, d_f;
  logic a_v, b_v, c_v, d_v;

  always_comb begin
    up_f = '0;
    dn_f = '0;
    up_f[FLOORS-2:0] = pend_up;
    dn_f[FLOORS-1:1] = pend_dn;
    cur = (int'(cur_floor) > FLOORS-1) ? FLOORS-1 : int'(cur_floor);
    a_v = 1'b0; a_f = 0;
    b_v = 1'b0; b_f = 0;
    c_v = 1'b0; c_f = 0;
    d_v = 1'b0; d_f = 0;
    // a: nearest car/up above, d: lowest up below (descending scan keeps the lowest)
    for (int f = FLOORS-1; f >= 0; f--) begin
      if (f > cur && (pend_car[f] || up_f[f])) begin a_v = 1'b1; a_f = f; end
      if (f < cur && up_f[f]) begin d_v = 1'b1; d_f = f; end
    end
    // b: highest down above, c: nearest car/down below
    for (int f = 0; f < FLOORS; f++) begin
      if (f > cur && dn_f[f]) begin b_v = 1'b1; b_f = f; end
      if (f < cur && (pend_car[f] || dn_f[f])) begin c_v = 1'b1; c_f = f; end
    end

    pick_valid = |{pend_car, pend_up, pend_dn};
    pick_floor = '0;
    pick_dir   = dir;
    if (pend_car[cur] || (dir == DIR_UP ? up_f[cur] : dn_f[cur])) begin
      pick_floor = FLOOR_W'(cur);
    end else if (dir == DIR_UP) begin
      if (a_v)      pick_floor = FLOOR_W'(a_f);
      else if (b_v) pick_floor = FLOOR_W'(b_f);
      else begin
        pick_dir = DIR_DN;
        if (dn_f[cur]) pick_floor = FLOOR_W'(cur);
        else if (c_v)  pick_floor = FLOOR_W'(c_f);
        else if (d_v)  pick_floor = FLOOR_W'(d_f);
      end
    end else begin
      if (c_v)      pick_floor = FLOOR_W'(c_f);
      else if (d_v) pick_floor = FLOOR_W'(d_f);
      else begin
        pick_dir = DIR_UP;
        if (up_f[cur]) pick_floor = FLOOR_W'(cur);
        else if (a_v)  pick_floor = FLOOR_W'(a_f);
        else if (b_v)  pick_floor = FLOOR_W'(b_f);
      end
    end
  end

endmodule

// File: rtl/call_scheduler.sv
// LOOK call scheduler: latches calls, hands stops to the motion FSM, clears served calls.
//   state    | meaning
//   IDLE     | no target; waits for any pending call
//   SELECT   | registers the LOOK pick and sweep direction
//   DISPATCH | target offered, waiting for tgt_ack
//   SERVE    | car moving; may retarget to a closer stop on the way
//   CLEAR    | car at floor; drops calls served there
module call_scheduler
  import elev_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  car_call,
  input  logic [FLOORS-2:0]  hall_up,
  input  logic [FLOORS-2:0]  hall_dn,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               tgt_ack,
  input  logic               arrived,
  output logic [FLOOR_W-1:0] tgt_floor,
  output logic               tgt_dir,
  output logic               tgt_valid,
  output logic               retarget,
  output logic [FLOORS-1:0]  pend_car,
  output logic [FLOORS-2:0]  pend_up,
  output logic [FLOORS-2:0]  pend_dn,
  output logic               idle
);

  state_t state_q, state_d;
  logic dir_q;
  logic load_tgt, retgt, between, any_pend;
  logic [FLOOR_W-1:0] cur_sat;
  logic [FLOORS-1:0] clr_car;
  logic [FLOORS-2:0] clr_up, clr_dn;
  logic pick_valid, pick_dir;
  logic [FLOOR_W-1:0] pick_floor;

  look_picker u_picker (
    .pend_car   (pend_car),
    .pend_up    (pend_up),
    .pend_dn    (pend_dn),
    .cur_floor  (cur_floor),
    .dir        (dir_q),
    .pick_valid (pick_valid),
    .pick_floor (pick_floor),
    .pick_dir   (pick_dir)
  );

  assign cur_sat   = (int'(cur_floor) > FLOORS-1) ? FLOOR_W'(FLOORS-1) : cur_floor;
  assign any_pend  = |{pend_car, pend_up, pend_dn};
  assign tgt_valid = (state_q == DISPATCH) || (state_q == SERVE);
  assign idle      = (state_q == IDLE) && !any_pend;

  always_comb begin
    state_d  = state_q;
    load_tgt = 1'b0;
    retgt    = 1'b0;
    clr_car  = '0;
    clr_up   = '0;
    clr_dn   = '0;
    if (tgt_dir == DIR_UP) between = (pick_floor > cur_sat) && (pick_floor < tgt_floor);
    else                   between = (pick_floor < cur_sat) && (pick_floor > tgt_floor);
    case (state_q)
      IDLE:     if (any_pend) state_d = SELECT;
      SELECT: begin
        if (pick_valid) begin
          load_tgt = 1'b1;
          state_d  = DISPATCH;
        end else begin
          state_d = IDLE;
        end
      end
      DISPATCH: if (tgt_ack) state_d = SERVE;
      SERVE: begin
        if (arrived) state_d = CLEAR;
        else if (pick_valid && between) retgt = 1'b1;
      end
      CLEAR: begin
        clr_car[cur_sat] = 1'b1;
        // terminal floors have only one hall button, so it is always served
        if ((dir_q == DIR_UP || cur_sat == '0) && int'(cur_sat) < FLOORS-1)
          clr_up[cur_sat] = 1'b1;
        if ((dir_q == DIR_DN || int'(cur_sat) == FLOORS-1) && cur_sat != '0)
          clr_dn[cur_sat - 1'b1] = 1'b1;
        state_d = SELECT;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      tgt_floor <= '0;
      tgt_dir   <= 1'b0;
      retarget  <= 1'b0;
      pend_car  <= '0;
      pend_up   <= '0;
      pend_dn   <= '0;
    end else begin
      state_q  <= state_d;
      pend_car <= (pend_car | car_call) & ~clr_car;
      pend_up  <= (pend_up | hall_up) & ~clr_up;
      pend_dn  <= (pend_dn | hall_dn) & ~clr_dn;
      retarget <= retgt;
      if (load_tgt) begin
        tgt_floor <= pick_floor;
        tgt_dir   <= pick_dir;
        dir_q     <= pick_dir;
      end else if (retgt) begin
        tgt_floor <= pick_floor;
      end
    end
  end

endmodule

// File: tb/tb_call_scheduler.sv
// Scenario bench for call_scheduler with a floor-array LOOK reference model.
module tb_call_scheduler;
  import elev_pkg::*;

  localparam int F = FLOORS;
  localparam int W = FLOOR_W;

  logic clk = 1'b0;
  logic rst;
  logic [F-1:0] car_call;
  logic [F-2:0] hall_up, hall_dn;
  logic [W-1:0] cur_floor;
  logic tgt_ack, arrived;
  logic [W-1:0] tgt_floor;
  logic tgt_dir, tgt_valid, retarget, idle;
  logic [F-1:0] pend_car;
  logic [F-2:0] pend_up, pend_dn;

  int n_checks = 0;
  int n_fail = 0;

  bit m_car[F];
  bit m_up[F];
  bit m_dn[F];
  bit m_dir;

  call_scheduler dut (
    .clk(clk), .rst(rst), .car_call(car_call), .hall_up(hall_up), .hall_dn(hall_dn),
    .cur_floor(cur_floor), .tgt_ack(tgt_ack), .arrived(arrived),
    .tgt_floor(tgt_floor), .tgt_dir(tgt_dir), .tgt_valid(tgt_valid), .retarget(retarget),
    .pend_car(pend_car), .pend_up(pend_up), .pend_dn(pend_dn), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int f = 0; f < F; f++) begin
      m_car[f] = 1'b0; m_up[f] = 1'b0; m_dn[f] = 1'b0;
    end
    m_dir = 1'b1;
  endtask

  task automatic do_reset();
    car_call = '0; hall_up = '0; hall_dn = '0; tgt_ack = 1'b0; arrived = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic press(input logic [F-1:0] c, input logic [F-2:0] u, input logic [F-2:0] d);
    car_call = c; hall_up = u; hall_dn = d;
    for (int f = 0; f < F; f++) m_car[f] |= c[f];
    for (int i = 0; i < F-1; i++) begin
      m_up[i]   |= u[i];
      m_dn[i+1] |= d[i];
    end
    step();
    car_call = '0; hall_up = '0; hall_dn = '0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (tgt_valid === 1'b1) begin ok = 1'b1; break; end
      step();
    end
  endtask

  function automatic int sat(input int c);
    return (c > F-1) ? F-1 : c;
  endfunction

  // LOOK rule applied directly to per-floor call flags
  function automatic void model_pick(input int cur, input bit d, output bit v, output int fl, output bit nd);
    bit any_c;
    any_c = 1'b0;
    for (int f = 0; f < F; f++) any_c |= m_car[f] | m_up[f] | m_dn[f];
    v = any_c; fl = 0; nd = d;
    if (!any_c) return;
    for (int p = 0; p < 2; p++) begin
      bit dd;
      bit others;
      dd = (p == 0) ? d : ~d;
      others = 1'b0;
      for (int f = 0; f < F; f++) if (f != cur && (m_car[f] | m_up[f] | m_dn[f])) others = 1'b1;
      if (m_car[cur] || (dd && m_up[cur]) || (!dd && m_dn[cur])) begin fl = cur; nd = dd; return; end
      if (!others && (m_up[cur] || m_dn[cur])) begin fl = cur; nd = m_up[cur]; return; end
      if (dd) begin
        for (int f = cur + 1; f < F; f++) if (m_car[f] || m_up[f]) begin fl = f; nd = 1'b1; return; end
        for (int f = F - 1; f > cur; f--) if (m_dn[f]) begin fl = f; nd = 1'b1; return; end
      end else begin
        for (int f = cur - 1; f >= 0; f--) if (m_car[f] || m_dn[f]) begin fl = f; nd = 1'b0; return; end
        for (int f = 0; f < cur; f++) if (m_up[f]) begin fl = f; nd = 1'b0; return; end
      end
    end
  endfunction

  function automatic logic [3*F-3:0] model_pend();
    logic [F-1:0] c;
    logic [F-2:0] u, d;
    for (int f = 0; f < F; f++) c[f] = m_car[f];
    for (int i = 0; i < F-1; i++) begin u[i] = m_up[i]; d[i] = m_dn[i+1]; end
    return {c, u, d};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_clear();
    n_checks++; if (pend_car !== 6'b0 || pend_up !== 5'b0 || pend_dn !== 5'b0) begin
      n_fail++; $display("FAIL reset_pend got=%b/%b/%b exp=0", pend_car, pend_up, pend_dn); end
    n_checks++; if (tgt_valid !== 1'b0 || retarget !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b,%b exp=0,0", tgt_valid, retarget); end
    n_checks++; if (tgt_floor !== 3'd0 || tgt_dir !== 1'b0) begin
      n_fail++; $display("FAIL reset_tgt got=%0d,%b exp=0,0", tgt_floor, tgt_dir); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
  endtask

  task automatic test_basic();
    do_reset();
    cur_floor = 3'd0;
    press(6'b010000, '0, '0);
    n_checks++; if (pend_car !== 6'b010000 || tgt_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latch got=%b,%b exp=010000,0", pend_car, tgt_valid); end
    step();
    n_checks++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got=%b exp=0", tgt_valid); end
    step();
    n_checks++; if (tgt_valid !== 1'b1 || tgt_floor !== 3'd4 || tgt_dir !== 1'b1) begin
      n_fail++; $display("FAIL basic_dispatch got=%b,%0d,%b exp=1,4,1", tgt_valid, tgt_floor, tgt_dir); end
    tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
    n_checks++; if (tgt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_serve got=%b exp=1", tgt_valid); end
    cur_floor = 3'd4; arrived = 1'b1; step(); arrived = 1'b0;
    n_checks++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_clear_valid got=%b exp=0", tgt_valid); end
    step();
    n_checks++; if (pend_car !== 6'b0) begin n_fail++; $display("FAIL basic_cleared got=%b exp=0", pend_car); end
    step();
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL basic_idle got=%b exp=1", idle); end
  endtask

  task automatic test_retarget();
    bit ok;
    do_reset();
    cur_floor = 3'd0;
    press(6'b100000, '0, '0);
    wait_valid(6, ok);
    n_checks++; if (!ok || tgt_floor !== 3'd5) begin
      n_fail++; $display("FAIL rt_dispatch got=%b,%0d exp=1,5", ok, tgt_floor); end
    tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
    cur_floor = 3'd1;
    press('0, '0, 5'b00010);
    step();
    n_checks++; if (retarget !== 1'b0 || tgt_floor !== 3'd5) begin
      n_fail++; $display("FAIL rt_dn_ignored got=%b,%0d exp=0,5", retarget, tgt_floor); end
    press('0, 5'b00100, '0);
    n_checks++; if (retarget !== 1'b0) begin n_fail++; $display("FAIL rt_early got=%b exp=0", retarget); end
    step();
    n_checks++; if (retarget !== 1'b1 || tgt_floor !== 3'd2 || tgt_dir !== 1'b1) begin
      n_fail++; $display("FAIL rt_pulse got=%b,%0d,%b exp=1,2,1", retarget, tgt_floor, tgt_dir); end
    step();
    n_checks++; if (retarget !== 1'b0) begin n_fail++; $display("FAIL rt_one_cycle got=%b exp=0", retarget); end
  endtask

  task automatic test_dir_flip();
    bit ok;
    do_reset();
    cur_floor = 3'd3;
    press(6'b000001, '0, 5'b00001);
    wait_valid(6, ok);
    n_checks++; if (!ok || tgt_floor !== 3'd1 || tgt_dir !== 1'b0) begin
      n_fail++; $display("FAIL flip_pick got=%b,%0d,%b exp=1,1,0", ok, tgt_floor, tgt_dir); end
    tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
    cur_floor = 3'd1; arrived = 1'b1; step(); arrived = 1'b0;
    step();
    n_checks++; if (pend_dn !== 5'b0 || pend_car !== 6'b000001) begin
      n_fail++; $display("FAIL flip_clear got=%b,%b exp=00000,000001", pend_dn, pend_car); end
    step();
    n_checks++; if (tgt_valid !== 1'b1 || tgt_floor !== 3'd0 || tgt_dir !== 1'b0) begin
      n_fail++; $display("FAIL flip_next got=%b,%0d,%b exp=1,0,0", tgt_valid, tgt_floor, tgt_dir); end
  endtask

  task automatic test_both_halls();
    bit ok;
    do_reset();
    cur_floor = 3'd2;
    press('0, 5'b00100, 5'b00010);
    wait_valid(6, ok);
    n_checks++; if (!ok || tgt_floor !== 3'd2 || tgt_dir !== 1'b1) begin
      n_fail++; $display("FAIL both_first got=%b,%0d,%b exp=1,2,1", ok, tgt_floor, tgt_dir); end
    tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
    arrived = 1'b1; step(); arrived = 1'b0;
    step();
    n_checks++; if (pend_up !== 5'b0 || pend_dn !== 5'b00010) begin
      n_fail++; $display("FAIL both_clear_up got=%b,%b exp=00000,00010", pend_up, pend_dn); end
    step();
    n_checks++; if (tgt_valid !== 1'b1 || tgt_floor !== 3'd2 || tgt_dir !== 1'b0) begin
      n_fail++; $display("FAIL both_second got=%b,%0d,%b exp=1,2,0", tgt_valid, tgt_floor, tgt_dir); end
    tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
    arrived = 1'b1; step(); arrived = 1'b0;
    step(); step();
    n_checks++; if (pend_dn !== 5'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL both_done got=%b,%b exp=00000,1", pend_dn, idle); end
  endtask

  task automatic test_clear_wins();
    bit ok;
    do_reset();
    cur_floor = 3'd0;
    press(6'b001000, '0, '0);
    wait_valid(6, ok);
    tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
    cur_floor = 3'd3; arrived = 1'b1; step(); arrived = 1'b0;
    car_call = 6'b001000; step(); car_call = '0;
    n_checks++; if (!ok || pend_car !== 6'b0) begin
      n_fail++; $display("FAIL clear_wins got=%b,%b exp=1,000000", ok, pend_car); end
    step();
    n_checks++; if (pend_car !== 6'b0) begin n_fail++; $display("FAIL clear_wins_hold got=%b exp=0", pend_car); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    cur_floor = 3'd0;
    press(6'b101000, '0, 5'b01000);
    wait_valid(6, ok);
    tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    model_clear();
    n_checks++; if (!ok || pend_car !== 6'b0 || pend_up !== 5'b0 || pend_dn !== 5'b0 || tgt_valid !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got=%b %b %b %b v=%b i=%b exp=all clear, idle", ok, pend_car, pend_up, pend_dn, tgt_valid, idle); end
    arrived = 1'b1; step(); arrived = 1'b0;
    step();
    n_checks++; if (tgt_valid !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL mid_arrived got=%b,%b exp=0,1", tgt_valid, idle); end
  endtask

  task automatic test_saturate();
    bit ok;
    do_reset();
    cur_floor = 3'd7;
    press(6'b100000, '0, '0);
    wait_valid(6, ok);
    n_checks++; if (!ok || tgt_floor !== 3'd5 || tgt_dir !== 1'b1) begin
      n_fail++; $display("FAIL saturate got=%b,%0d,%b exp=1,5,1", ok, tgt_floor, tgt_dir); end
  endtask

  task automatic test_random();
    bit v, nd, exp_rt, m_tdir;
    int fl, m_tgt, cur, ne;
    logic [F-1:0] c;
    logic [F-2:0] u, d;
    do_reset();
    cur = int'($urandom_range(0, 7));
    cur_floor = W'(cur);
    c = F'($urandom);
    if (c == '0) c = 6'b000001;
    press(c, '0, '0);
    step(); step();
    model_pick(sat(cur), m_dir, v, fl, nd);
    m_dir = nd; m_tgt = fl; m_tdir = nd;
    n_checks++; if (tgt_valid !== 1'b1 || tgt_floor !== W'(fl) || tgt_dir !== nd) begin
      n_fail++; $display("FAIL rnd_start got=%b,%0d,%b exp=1,%0d,%b", tgt_valid, tgt_floor, tgt_dir, fl, nd); end
    for (int k = 0; k < 30; k++) begin
      tgt_ack = 1'b1; step(); tgt_ack = 1'b0;
      ne = int'($urandom_range(0, 2));
      for (int e = 0; e < ne; e++) begin
        c = F'($urandom & $urandom);
        u = (F-1)'($urandom & $urandom);
        d = (F-1)'($urandom & $urandom);
        press(c, u, d);
        step();
        model_pick(sat(cur), m_dir, v, fl, nd);
        exp_rt = v && (m_tdir ? (fl > sat(cur) && fl < m_tgt) : (fl < sat(cur) && fl > m_tgt));
        if (exp_rt) m_tgt = fl;
        n_checks++; if (retarget !== exp_rt || tgt_floor !== W'(m_tgt)) begin
          n_fail++; $display("FAIL rnd_retarget k=%0d got=%b,%0d exp=%b,%0d", k, retarget, tgt_floor, exp_rt, m_tgt); end
        step();
      end
      cur = m_tgt;
      cur_floor = W'(cur);
      arrived = 1'b1; step(); arrived = 1'b0;
      n_checks++; if (tgt_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_clear_valid k=%0d got=%b exp=0", k, tgt_valid); end
      m_car[cur] = 1'b0;
      if (m_dir || cur == 0) m_up[cur] = 1'b0;
      if (!m_dir || cur == F-1) m_dn[cur] = 1'b0;
      step();
      n_checks++; if ({pend_car, pend_up, pend_dn} !== model_pend()) begin
        n_fail++; $display("FAIL rnd_pend k=%0d got=%b exp=%b", k, {pend_car, pend_up, pend_dn}, model_pend()); end
      step();
      model_pick(cur, m_dir, v, fl, nd);
      if (!v) begin
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rnd_idle k=%0d got=%b exp=1", k, idle); end
        c = F'($urandom);
        if (c == '0) c = 6'b100000;
        press(c, '0, '0);
        step(); step();
        model_pick(cur, m_dir, v, fl, nd);
      end
      m_dir = nd; m_tgt = fl; m_tdir = nd;
      n_checks++; if (tgt_valid !== 1'b1 || tgt_floor !== W'(fl) || tgt_dir !== nd) begin
        n_fail++; $display("FAIL rnd_pick k=%0d got=%b,%0d,%b exp=1,%0d,%b", k, tgt_valid, tgt_floor, tgt_dir, fl, nd); end
    end
  endtask

  initial begin
    rst = 1'b1;
    car_call = '0; hall_up = '0; hall_dn = '0;
    cur_floor = '0; tgt_ack = 1'b0; arrived = 1'b0;
    test_reset();
    test_basic();
    test_retarget();
    test_dir_flip();
    test_both_halls();
    test_clear_wins();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
